// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state encoding, the NOP word and the address-legality helper.
`timescale 1ns/1ps
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // A byte address is usable when word-aligned and below 4 << aw.
    function automatic logic addr_ok(input logic [31:0] a, input int aw);
        return (a[1:0] == 2'b00) && ((a >> (aw + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; software loads the program before use.
`timescale 1ns/1ps
module imem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder: accepts a level req, waits LATENCY
// cycles, then pulses inst_ready for one cycle with the addressed word.
//
// Handshake: req is raised by the requester and held until inst_ready; the
// address is sampled on the accepting edge in IDLE. inst_ready is a one-cycle
// pulse; dropping req before the capture edge abandons the fetch silently.
`timescale 1ns/1ps
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic [31:0] addr,
    output logic        inst_ready,
    output logic [31:0] inst_data,
    output logic        addr_err,
    output logic        busy,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic [15:0] resp_cnt,
    output logic [1:0]  o_dbg_state
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_inst_data;
    logic          r_err;
    logic [15:0]   r_resp_cnt;

    logic          w_accept;
    logic          w_capture;
    logic          w_fetch_ok;
    logic          w_we;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_prog_idx;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_cap_word;

    assign w_idx      = r_addr[AW+1:2];
    assign w_prog_idx = prog_addr[AW+1:2];
    assign w_fetch_ok = addr_ok(r_addr, AW);
    assign w_we       = prog_we && addr_ok(prog_addr, AW);

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_prog_idx),
        .i_wdata (prog_data),
        .i_raddr (w_idx),
        .o_rdata (w_rd_word)
    );

    // A write landing on the fetched word at the capture edge wins over the array.
    assign w_cap_word = (w_we && (w_prog_idx == w_idx)) ? prog_data : w_rd_word;

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_next   = WAIT;
                    w_accept = 1'b1;
                end
            end
            WAIT: begin
                if (!req) begin
                    w_next = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next    = RESP;
                    w_capture = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_inst_data <= 32'd0;
            r_err       <= 1'b0;
            r_resp_cnt  <= 16'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= addr;
                r_cnt  <= LAT_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_inst_data <= w_fetch_ok ? w_cap_word : NOP_INSN;
                r_err       <= !w_fetch_ok;
            end
            if ((r_state == RESP) && (r_resp_cnt != 16'hFFFF)) begin
                r_resp_cnt <= r_resp_cnt + 16'd1;
            end
        end
    end

    assign inst_ready  = (r_state == RESP);
    assign addr_err    = inst_ready && r_err;
    assign busy        = (r_state != IDLE);
    assign inst_data   = r_inst_data;
    assign resp_cnt    = r_resp_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed fetches, abort, reset,
// back-to-back and randomized traffic against a transaction-level memory model.
`timescale 1ns/1ps
module tb_imem_responder;
    import imem_pkg::*;

    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic [31:0] addr;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic        addr_err;
    logic        busy;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic [15:0] resp_cnt;
    logic [1:0]  dbg_state;

    imem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .addr        (addr),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .addr_err    (addr_err),
        .busy        (busy),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .resp_cnt    (resp_cnt),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          exp_cnt = 0;
    logic [31:0] last_data = 32'd0;
    logic [31:0] mem_model [DEPTH];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (addr_valid(a)) return mem_model[int'(a / 4)];
        return 32'h0000_0013;
    endfunction

    // Drives one write strobe for the coming edge and mirrors it in the model.
    task automatic drive_prog(input logic [31:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        if (addr_valid(a)) mem_model[int'(a / 4)] = d;
    endtask

    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        drive_prog(a, d);
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Called at a negedge with the responder idle. abort_at: 0 = none, else the
    // WAIT cycle in which req is dropped. wr_mode: 0 none, 1 random, 2 hit on capture.
    task automatic fetch(input logic [31:0] a, input int abort_at, input int wr_mode);
        bit          exp_e;
        bit          exp_rdy;
        bit          exp_busy;
        logic [31:0] wa;
        req     = 1'b1;
        addr    = a;
        prog_we = 1'b0;
        exp_e   = !addr_valid(a);
        for (int n = 1; n <= LAT + 2; n++) begin
            @(negedge clk);
            prog_we  = 1'b0;
            exp_rdy  = (abort_at == 0) && (n == LAT + 1);
            exp_busy = (abort_at == 0) ? (n <= LAT + 1) : (n <= abort_at);
            check("inst_ready", 32'(inst_ready), 32'(exp_rdy));
            check("busy", 32'(busy), 32'(exp_busy));
            check("addr_err", 32'(addr_err), 32'(exp_rdy && exp_e));
            if (exp_rdy) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    last_data = exp_q.pop_front();
                    check("inst_data", inst_data, last_data);
                end
                check("resp_cnt_pre", 32'(resp_cnt), 32'(exp_cnt));
                if (exp_cnt < 16'hFFFF) exp_cnt++;
            end else begin
                check("inst_data_hold", inst_data, last_data);
            end
            if (n == LAT + 2) begin
                check("resp_cnt", 32'(resp_cnt), 32'(exp_cnt));
                check("state_idle", 32'(dbg_state), 32'(IDLE));
            end
            if (abort_at != 0 && n == abort_at) req = 1'b0;
            if (n == LAT + 1) req = 1'b0;
            if (n <= LAT) addr = $urandom;
            if (n <= LAT + 1) begin
                if (wr_mode == 2 && n == LAT) begin
                    drive_prog(a, 32'h1234_5678);
                end else if (wr_mode == 1 && $urandom_range(0, 2) == 0) begin
                    wa = 32'($urandom_range(0, DEPTH * 4 + 16));
                    drive_prog(wa, $urandom);
                end
            end
            if (n == LAT && abort_at == 0) exp_q.push_back(exp_e ? 32'h0000_0013 : model_read(a));
        end
    endtask

    task automatic reset_mid_wait();
        req  = 1'b1;
        addr = 32'h10;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_ready", 32'(inst_ready), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", inst_data, 32'd0);
        check("rst_cnt", 32'(resp_cnt), 32'd0);
        exp_cnt   = 0;
        last_data = 32'd0;
        req       = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (LAT + 3) begin
            @(negedge clk);
            check("post_rst_ready", 32'(inst_ready), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
    endtask

    // Continuous req for addresses 0, 4, 8: pulses every LAT+2 cycles.
    task automatic back_to_back();
        int j;
        bit exp_rdy;
        req  = 1'b1;
        addr = 32'h0;
        for (int n = 1; n <= 3 * (LAT + 2); n++) begin
            @(negedge clk);
            exp_rdy = 1'b0;
            j = 0;
            for (int k = 0; k < 3; k++) begin
                if (n == LAT + 1 + k * (LAT + 2)) begin
                    exp_rdy = 1'b1;
                    j = k;
                end
            end
            check("b2b_ready", 32'(inst_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                last_data = model_read(32'(j * 4));
                check("b2b_data", inst_data, last_data);
                check("b2b_err", 32'(addr_err), 32'd0);
                exp_cnt++;
                if (j < 2) addr = 32'((j + 1) * 4);
                else req = 1'b0;
            end
        end
        check("b2b_cnt", 32'(resp_cnt), 32'(exp_cnt));
    endtask

    initial begin
        logic [31:0] ra;
        int          sel;
        rstn      = 1'b0;
        req       = 1'b0;
        addr      = 32'd0;
        prog_we   = 1'b0;
        prog_addr = 32'd0;
        prog_data = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", 32'(inst_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(addr_err), 32'd0);
        check("reset_data", inst_data, 32'd0);
        check("reset_cnt", 32'(resp_cnt), 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < DEPTH; i++) prog_write(32'(i * 4), $urandom);
        prog_write(32'h4, 32'hDEAD_BEEF);
        prog_write(32'h6, 32'hBAD0_0001);
        prog_write(32'(DEPTH * 4 + 4), 32'hBAD0_0002);

        fetch(32'h4, 0, 0);
        check("deadbeef", last_data, 32'hDEAD_BEEF);
        fetch(32'h6, 0, 0);
        fetch(32'h8, 2, 0);
        fetch(32'hC, 0, 2);
        check("bypass", last_data, 32'h1234_5678);
        fetch(32'(DEPTH * 4 + 4), 0, 0);
        fetch(32'h4, 0, 0);

        @(negedge clk);
        reset_mid_wait();
        back_to_back();
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 19);
            if (sel < 14) ra = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel < 17) ra = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
            else ra = $urandom;
            fetch(ra, ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT) : 0,
                  $urandom_range(0, 2));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words; power of two, at least 2.
REQ-002 SHALL have parameter LATENCY, default 3, cycles from request acceptance to inst_ready; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  fetch request from instruction cache, level, held until inst_ready.
REQ-006 SHALL have port addr  input  32  byte address of requested instruction.
REQ-007 SHALL have port inst_ready  output  1  one-cycle pulse, inst_data valid.
REQ-008 SHALL have port inst_data  output  32  returned instruction word.
REQ-009 SHALL have port addr_err  output  1  pulses with inst_ready when the address was misaligned or out of range.
REQ-010 SHALL have port busy  output  1  high in WAIT and RESP.
REQ-011 SHALL have port prog_we  input  1  program-write strobe.
REQ-012 SHALL have port prog_addr  input  32  program-write byte address.
REQ-013 SHALL have port prog_data  input  32  program-write data.
REQ-014 SHALL have port resp_cnt  output  16  completed-response counter.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 IDLE with req=1 SHALL latch addr, load latency counter with LATENCY-1, enter WAIT next cycle.
REQ-017 WAIT SHALL decrement the counter each cycle; at counter=0 with req=1 it SHALL register the word and enter RESP.
REQ-018 WAIT with req=0 SHALL abort to IDLE next cycle; no inst_ready, resp_cnt unchanged.
REQ-019 RESP SHALL drive inst_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 Total latency SHALL be LATENCY+1 cycles from the req-high edge in IDLE to the inst_ready cycle.
REQ-021 A req held high in the cycle after RESP SHALL start a new transaction from IDLE; back-to-back requests are never accepted in RESP.
REQ-022 addr changes after acceptance SHALL be ignored; the latched address is used.
REQ-023 Word index SHALL be latched addr[log2(DEPTH)+1:2].
REQ-024 If addr[1:0]!=0 or addr>=DEPTH*4, inst_data SHALL be 32'h00000013 (NOP) and addr_err SHALL pulse with inst_ready.
REQ-025 inst_data SHALL hold its value outside RESP; addr_err SHALL be 0 outside RESP.
REQ-026 prog_we SHALL write prog_data to word prog_addr[log2(DEPTH)+1:2] in any state; out-of-range or misaligned writes SHALL be dropped.
REQ-027 A program write to the latched index in the same cycle as the WAIT-to-RESP capture SHALL return the new prog_data (write-first bypass).
REQ-028 resp_cnt SHALL increment on each inst_ready and saturate at 16'hFFFF.

Reset
REQ-029 rstn low SHALL force IDLE, counter 0, inst_ready 0, addr_err 0, busy 0, inst_data 0, resp_cnt 0, asynchronously.
REQ-030 Reset mid-transaction SHALL discard it; no inst_ready SHALL follow reset release without a new req.
REQ-031 Memory contents SHALL NOT be cleared by reset; the bench programs them before use.

Structure
REQ-032 The shared package imem_pkg SHALL hold the state typedef (IDLE/WAIT/RESP) and the NOP constant 32'h00000013.
REQ-033 Storage SHALL be a sub-module imem_array: one write port, one combinational read port, no reset.

Verification
REQ-034 Program word 1 = 32'hDEADBEEF, req with addr 32'h4, LATENCY=3 -> inst_ready exactly 4 cycles later, inst_data DEADBEEF, addr_err 0, resp_cnt 1.
REQ-035 req with addr 32'h6 -> inst_ready after LATENCY+1 cycles, inst_data 32'h00000013, addr_err 1.
REQ-036 req dropped on the 2nd WAIT cycle -> no inst_ready, FSM in IDLE, resp_cnt unchanged.
REQ-037 rstn pulsed low during WAIT -> all outputs 0 immediately, no inst_ready after release.
REQ-038 prog_we to the latched index on the capture cycle with data 32'h12345678 -> inst_data 12345678.
REQ-039 Continuous req for 3 fetches (addr 0, 4, 8) -> three inst_ready pulses spaced LATENCY+2 cycles apart, resp_cnt 3.
